multi_core_scheduler: RTL and testbench
=======================================

# multi_core_scheduler

Control and aggregation block for a parametrised array of lockstep processor cores. It launches a run on a runtime-selected subset of cores and nominates the lowest-numbered active core as leader, driving the shared instruction and data memory buses from it. A run completes only when every active core has reported done; a lockstep address mismatch or a cycle timeout ends the run with an error instead. It sits between the top level and the core array, replacing fixed core-0 forwarding.

## Interface
- CORE_COUNT, 4, number of cores (1..32)
- DATA_MEM_ADDR_WIDTH, 12, data memory address width
- INS_MEM_ADDR_WIDTH, 8, instruction memory address width
- TIMEOUT_WIDTH, 16, width of the timeout limit and the cycle counter

- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  launch request; acknowledges errors in ERROR
- coreMask  in  CORE_COUNT  cores to run, sampled at launch
- timeoutLimit  in  TIMEOUT_WIDTH  maximum RUN cycles; 0 disables the timeout; sampled at launch
- core_done  in  CORE_COUNT  per-core done level
- core_insMemAddr  in  CORE_COUNT*INS_MEM_ADDR_WIDTH  packed; core i at [i*W +: W]
- core_dataMemAddr  in  CORE_COUNT*DATA_MEM_ADDR_WIDTH  packed, same layout
- core_DataMemWrEn  in  CORE_COUNT  per-core data write enable
- coreStart  out  CORE_COUNT  one-cycle start pulse to each active core
- insMemAddr  out  INS_MEM_ADDR_WIDTH  leader instruction address
- dataMemAddr  out  DATA_MEM_ADDR_WIDTH  leader data address
- DataMemWrEn  out  1  leader write enable, gated to 0 outside RUN
- ready  out  1  high in IDLE
- busy  out  1  high in LAUNCH and RUN
- done  out  1  one-cycle pulse on successful completion
- lockstepErr, timeoutErr  out  1 each  sticky error flags
- doneMask  out  CORE_COUNT  active cores that have reported done
- cycleCount  out  TIMEOUT_WIDTH  number of RUN cycles in the current or last run

## Operation
- States:
  - IDLE: wait for a launch.
  - LAUNCH: pulse the cores.
  - RUN: wait for completion or error.
  - DONE: one-cycle completion state.
  - ERROR: hold until acknowledged.
- IDLE:
  - start=1 with coreMask≠0: latch activeMask=coreMask, the timeout limit, and leader = index of the lowest set bit of coreMask. Go to LAUNCH.
  - start=1 with coreMask=0: ignored; stay in IDLE.
- LAUNCH:
  - coreStart = activeMask for exactly this cycle.
  - Clear cycleCount, doneMask, lockstepErr and timeoutErr.
  - Go to RUN.
- RUN, each cycle:
  - doneMask |= core_done & activeMask.
  - cycleCount += 1, saturating at all-ones.
- Lockstep check: in RUN, every active core not yet in doneMask must present the same insMemAddr, dataMemAddr and DataMemWrEn as the leader. Cores already done are excluded.
- Exits from RUN, in priority order:
  1. Any lockstep mismatch: set lockstepErr and go to ERROR.
  2. (doneMask | core_done&activeMask) == activeMask: go to DONE.
  3. timeoutLimit≠0 and cycleCount == timeoutLimit: set timeoutErr and go to ERROR.
- DONE: done=1 for this cycle, then go to IDLE.
- ERROR: hold the flags. start=1 returns to IDLE without launching.
- The bus outputs are a combinational mux of the registered leader index. leader holds its value between runs.
- doneMask and cycleCount hold their values after DONE or ERROR until the next LAUNCH.

## Timing
- Reset values:
  - state IDLE, so ready=1.
  - busy=0, done=0, coreStart=0, lockstepErr=0, timeoutErr=0.
  - doneMask=0, cycleCount=0, leader=0.
  - DataMemWrEn=0.
- Launch sequence: start sampled at edge T; coreStart is high during cycle T+1; RUN begins at T+2.
- Completion: the last core_done sampled at edge N gives done=1 during N+1, and ready=1 from N+2.
- Errors are registered: the flag and the ERROR state are both visible in the cycle after detection.
- Timeout: with timeoutLimit=L, ERROR is entered after L+1 RUN cycles, and cycleCount reads L+1.
- start is ignored in LAUNCH, RUN and DONE.
- rst asserted mid-run returns everything to its reset values on the next edge; no coreStart or done pulse is produced.

## Test plan
- Full run: coreMask=4'b1111, timeoutLimit=0; cores raise done at RUN cycles 3, 5, 5, 9.
  - coreStart=4'b1111 for one cycle.
  - One done pulse after core 3's done.
  - doneMask=4'b1111, cycleCount=9.
- Leader selection: coreMask=4'b1100, cores 2 and 3 drive insMemAddr 0x10 and 0x10, core 0 drives 0x55.
  - insMemAddr=0x10 and no lockstepErr, because core 0 is inactive.
- Lockstep fault: with coreMask=4'b0011, core 1 drives dataMemAddr 0x123 while the leader drives 0x122 in RUN cycle 2.
  - lockstepErr=1 and state ERROR; no done pulse.
  - A subsequent start returns to IDLE with ready=1.
- Timeout: coreMask=4'b0001, timeoutLimit=5, core never done.
  - timeoutErr=1 with cycleCount=6.
  - Repeat with done arriving in the same cycle as the timeout: the run completes with done=1 and no error.
- Edge cases:
  - start with coreMask=0: no state change, ready stays 1.
  - rst asserted in RUN cycle 4: all outputs return to their reset values on the next edge.
  - A start held across LAUNCH and RUN launches exactly one run.

Source files
------------

// File: rtl/multi_core_scheduler.sv
// rtl/multi_core_scheduler.sv - launch, lockstep-check and completion control for a lockstep core array
//
// Launches a run on the cores selected by coreMask, nominates the lowest-numbered
// active core as leader and forwards its memory buses, and finishes the run when
// every active core has reported done, or with an error on a lockstep mismatch or
// a cycle timeout.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      launch request (IDLE), error acknowledge (ERROR)
//   coreMask, timeoutLimit     run configuration, sampled at launch
//   core_done                  per-core done levels
//   core_insMemAddr            packed per-core instruction addresses
//   core_dataMemAddr           packed per-core data addresses
//   core_DataMemWrEn           per-core data write enables
//   coreStart                  one-cycle start pulse to the active cores
//   insMemAddr, dataMemAddr    leader buses
//   DataMemWrEn                leader write enable, forced low outside RUN
//   ready, busy, done          status (IDLE / LAUNCH+RUN / completion pulse)
//   lockstepErr, timeoutErr    sticky error flags, cleared at the next launch
//   doneMask, cycleCount       progress of the current or last run
module multi_core_scheduler #(
    parameter int CORE_COUNT          = 4,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int INS_MEM_ADDR_WIDTH  = 8,
    parameter int TIMEOUT_WIDTH       = 16
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [CORE_COUNT-1:0]                     coreMask,
    input  logic [TIMEOUT_WIDTH-1:0]                  timeoutLimit,
    input  logic [CORE_COUNT-1:0]                     core_done,
    input  logic [CORE_COUNT*INS_MEM_ADDR_WIDTH-1:0]  core_insMemAddr,
    input  logic [CORE_COUNT*DATA_MEM_ADDR_WIDTH-1:0] core_dataMemAddr,
    input  logic [CORE_COUNT-1:0]                     core_DataMemWrEn,
    output logic [CORE_COUNT-1:0]                     coreStart,
    output logic [INS_MEM_ADDR_WIDTH-1:0]             insMemAddr,
    output logic [DATA_MEM_ADDR_WIDTH-1:0]            dataMemAddr,
    output logic                                      DataMemWrEn,
    output logic                                      ready,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      lockstepErr,
    output logic                                      timeoutErr,
    output logic [CORE_COUNT-1:0]                     doneMask,
    output logic [TIMEOUT_WIDTH-1:0]                  cycleCount
);

    localparam int IW = INS_MEM_ADDR_WIDTH;
    localparam int DW = DATA_MEM_ADDR_WIDTH;
    localparam int TW = TIMEOUT_WIDTH;
    localparam int LW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CORE_COUNT-1:0] active_mask;
    logic [CORE_COUNT-1:0] done_mask;
    logic [TW-1:0]       timeout_lim;
    logic [TW-1:0]       cycle_count;
    logic [LW-1:0]       leader;
    logic [LW-1:0]       first_set;
    logic                lockstep_err;
    logic                timeout_err;
    logic [IW-1:0]       lead_ins;
    logic [DW-1:0]       lead_data;
    logic                lead_we;
    logic                mismatch;
    logic                all_done;
    logic                timeout_hit;

    // Lowest set bit of coreMask; scanning downwards lets the lowest index win.
    always_comb begin
        first_set = '0;
        for (int i = CORE_COUNT - 1; i >= 0; i--) begin
            if (coreMask[i]) begin
                first_set = LW'(i);
            end
        end
    end

    always_comb begin
        lead_ins  = core_insMemAddr[int'(leader)*IW +: IW];
        lead_data = core_dataMemAddr[int'(leader)*DW +: DW];
        lead_we   = core_DataMemWrEn[int'(leader)];
    end

    // Cores already latched in done_mask have left lockstep and are not compared.
    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (active_mask[i] && !done_mask[i]) begin
                if (core_insMemAddr[i*IW +: IW] != lead_ins ||
                    core_dataMemAddr[i*DW +: DW] != lead_data ||
                    core_DataMemWrEn[i] != lead_we) begin
                    mismatch = 1'b1;
                end
            end
        end
    end

    // Completion includes this cycle's done levels, so a core finishing on the
    // timeout cycle still counts as a successful run.
    assign all_done    = ((done_mask | (core_done & active_mask)) == active_mask);
    assign timeout_hit = (timeout_lim != '0) && (cycle_count == timeout_lim);

    always_comb begin
        state_next = state;
        coreStart  = '0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start && (coreMask != '0)) begin
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                busy       = 1'b1;
                coreStart  = active_mask;
                state_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (mismatch) begin
                    state_next = S_ERROR;
                end else if (all_done) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_ERROR;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ERROR: begin
                if (start) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            active_mask  <= '0;
            timeout_lim  <= '0;
            leader       <= '0;
            done_mask    <= '0;
            cycle_count  <= '0;
            lockstep_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start && (coreMask != '0)) begin
                        active_mask <= coreMask;
                        timeout_lim <= timeoutLimit;
                        leader      <= first_set;
                    end
                end
                S_LAUNCH: begin
                    done_mask    <= '0;
                    cycle_count  <= '0;
                    lockstep_err <= 1'b0;
                    timeout_err  <= 1'b0;
                end
                S_RUN: begin
                    done_mask <= done_mask | (core_done & active_mask);
                    if (cycle_count != '1) begin
                        cycle_count <= cycle_count + TW'(1);
                    end
                    if (mismatch) begin
                        lockstep_err <= 1'b1;
                    end else if (!all_done && timeout_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign insMemAddr  = lead_ins;
    assign dataMemAddr = lead_data;
    assign DataMemWrEn = (state == S_RUN) && lead_we;
    assign lockstepErr = lockstep_err;
    assign timeoutErr  = timeout_err;
    assign doneMask    = done_mask;
    assign cycleCount  = cycle_count;

endmodule

// File: tb/tb_multi_core_scheduler.sv
// tb/tb_multi_core_scheduler.sv - randomized self-checking bench for multi_core_scheduler
module tb_multi_core_scheduler;

    localparam int NC = 4;
    localparam int IW = 8;
    localparam int DW = 12;
    localparam int TW = 16;
    localparam int NEVER = 9999;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NC-1:0]     coreMask;
    logic [TW-1:0]     timeoutLimit;
    logic [NC-1:0]     core_done;
    logic [NC*IW-1:0]  core_insMemAddr;
    logic [NC*DW-1:0]  core_dataMemAddr;
    logic [NC-1:0]     core_DataMemWrEn;
    logic [NC-1:0]     coreStart;
    logic [IW-1:0]     insMemAddr;
    logic [DW-1:0]     dataMemAddr;
    logic              DataMemWrEn;
    logic              ready;
    logic              busy;
    logic              done;
    logic              lockstepErr;
    logic              timeoutErr;
    logic [NC-1:0]     doneMask;
    logic [TW-1:0]     cycleCount;

    int n_vec = 0;
    int n_err = 0;
    int dcyc [NC];

    always #5 clk = ~clk;

    multi_core_scheduler #(
        .CORE_COUNT(NC), .DATA_MEM_ADDR_WIDTH(DW),
        .INS_MEM_ADDR_WIDTH(IW), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .coreMask(coreMask),
        .timeoutLimit(timeoutLimit), .core_done(core_done),
        .core_insMemAddr(core_insMemAddr), .core_dataMemAddr(core_dataMemAddr),
        .core_DataMemWrEn(core_DataMemWrEn), .coreStart(coreStart),
        .insMemAddr(insMemAddr), .dataMemAddr(dataMemAddr),
        .DataMemWrEn(DataMemWrEn), .ready(ready), .busy(busy), .done(done),
        .lockstepErr(lockstepErr), .timeoutErr(timeoutErr),
        .doneMask(doneMask), .cycleCount(cycleCount)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete run. The outcome is predicted up front from the run rules:
    // RUN cycle k sees doneMask = cores with dcyc <= k-1 and cycleCount = k-1.
    // rst_at > 0 asserts rst during that RUN cycle instead of finishing the run.
    task automatic do_run(input logic [NC-1:0] m, input int lim, input int fcore,
                          input int fcyc, input bit hold, input bit fixed, input int rst_at);
        int ld, maxd, kend, oc;
        logic [NC-1:0] exp_dm;
        logic [IW-1:0] ci;
        logic [DW-1:0] cd;
        logic          cw;

        if (ready !== 1'b1) do_reset();
        ld = -1;
        maxd = 0;
        for (int i = NC - 1; i >= 0; i--) if (m[i]) ld = i;
        for (int i = 0; i < NC; i++) if (m[i] && dcyc[i] > maxd) maxd = dcyc[i];
        kend = 0;
        oc = 0;
        for (int k = 1; k <= 500 && kend == 0; k++) begin
            if (fcore >= 0 && k == fcyc && dcyc[fcore] > k - 1) begin kend = k; oc = 1; end
            else if (maxd <= k) begin kend = k; oc = 0; end
            else if (lim != 0 && k == lim + 1) begin kend = k; oc = 2; end
        end
        exp_dm = '0;
        for (int i = 0; i < NC; i++) if (m[i] && dcyc[i] <= kend) exp_dm[i] = 1'b1;

        // IDLE: request launch
        @(negedge clk);
        start = 1'b1;
        coreMask = m;
        timeoutLimit = TW'(lim);
        core_done = '0;
        #1 chk("idle_ready", ready, 1);

        // LAUNCH
        @(negedge clk);
        start = hold;
        coreMask = NC'($urandom);
        timeoutLimit = TW'($urandom);
        core_DataMemWrEn = '1;
        #1;
        chk("launch_corestart", coreStart, m);
        chk("launch_busy", busy, 1);
        chk("launch_wren_gated", DataMemWrEn, 0);

        for (int k = 1; k <= kend; k++) begin
            @(negedge clk);
            ci = fixed ? 8'h10 : IW'($urandom);
            cd = fixed ? 12'h122 : DW'($urandom);
            cw = 1'($urandom);
            for (int i = 0; i < NC; i++) begin
                if (m[i]) begin
                    core_done[i] = (dcyc[i] <= k);
                    if (i != ld && dcyc[i] <= k - 1) begin
                        core_insMemAddr[i*IW +: IW]  = IW'($urandom);
                        core_dataMemAddr[i*DW +: DW] = DW'($urandom);
                        core_DataMemWrEn[i]          = 1'($urandom);
                    end else begin
                        core_insMemAddr[i*IW +: IW]  = ci;
                        core_dataMemAddr[i*DW +: DW] = (i == fcore && k == fcyc) ? (cd ^ 12'h1) : cd;
                        core_DataMemWrEn[i]          = cw;
                    end
                end else begin
                    core_done[i]                 = 1'($urandom);
                    core_insMemAddr[i*IW +: IW]  = fixed ? 8'h55 : IW'($urandom);
                    core_dataMemAddr[i*DW +: DW] = DW'($urandom);
                    core_DataMemWrEn[i]          = 1'($urandom);
                end
            end
            if (k == rst_at) rst = 1'b1;
            #1;
            chk("run_busy", busy, 1);
            chk("run_ready", ready, 0);
            chk("run_corestart", coreStart, 0);
            chk("run_ins", insMemAddr, ci);
            chk("run_data", dataMemAddr, cd);
            chk("run_wren", DataMemWrEn, cw);
            chk("run_cycles", cycleCount, k - 1);
            chk("run_err", {lockstepErr, timeoutErr}, 0);
            if (k == rst_at) begin
                @(negedge clk);
                rst = 1'b0;
                start = 1'b0;
                core_insMemAddr[IW-1:0] = 8'hA7;
                #1;
                chk("rst_ready", ready, 1);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_corestart", coreStart, 0);
                chk("rst_flags", {lockstepErr, timeoutErr}, 0);
                chk("rst_donemask", doneMask, 0);
                chk("rst_cycles", cycleCount, 0);
                chk("rst_wren", DataMemWrEn, 0);
                chk("rst_leader0", insMemAddr, 8'hA7);
                @(negedge clk);
                #1;
                chk("rst_quiet", {coreStart, done}, 0);
                return;
            end
        end

        // first cycle after the run ends: DONE or ERROR
        @(negedge clk);
        start = 1'b0;
        core_DataMemWrEn = '1;
        #1;
        chk("end_busy", busy, 0);
        chk("end_ready", ready, 0);
        chk("end_done", done, (oc == 0) ? 1 : 0);
        chk("end_lockstep", lockstepErr, (oc == 1) ? 1 : 0);
        chk("end_timeout", timeoutErr, (oc == 2) ? 1 : 0);
        chk("end_donemask", doneMask, exp_dm);
        chk("end_cycles", cycleCount, kend);
        chk("end_wren_gated", DataMemWrEn, 0);
        if (oc != 0) begin
            @(negedge clk);
            #1;
            chk("err_hold_ready", ready, 0);
            chk("err_hold_flags", {lockstepErr, timeoutErr}, (oc == 1) ? 2 : 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end else begin
            @(negedge clk);
        end
        #1;
        chk("after_ready", ready, 1);
        chk("after_done", done, 0);
        chk("after_donemask", doneMask, exp_dm);
        chk("after_cycles", cycleCount, kend);
        chk("after_corestart", coreStart, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc, fcy, lim;
        logic [NC-1:0] m;

        start = 1'b0;
        coreMask = '0;
        timeoutLimit = '0;
        core_done = '0;
        core_insMemAddr = '0;
        core_dataMemAddr = '0;
        core_DataMemWrEn = '1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_status", {busy, done, coreStart}, 0);
        chk("reset_flags", {lockstepErr, timeoutErr}, 0);
        chk("reset_donemask", doneMask, 0);
        chk("reset_cycles", cycleCount, 0);
        chk("reset_wren", DataMemWrEn, 0);
        @(negedge clk);
        rst = 1'b0;

        // start with an empty mask is ignored
        start = 1'b1;
        coreMask = '0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("empty_mask_ready", ready, 1);
            chk("empty_mask_corestart", coreStart, 0);
        end
        start = 1'b0;

        // full run, dones at 3,5,5,9, start held across LAUNCH/RUN
        dcyc = '{3, 5, 5, 9};
        do_run(4'b1111, 0, -1, 0, 1'b1, 1'b0, 0);
        // leader selection with inactive core 0
        dcyc = '{NEVER, NEVER, 4, 6};
        do_run(4'b1100, 0, -1, 0, 1'b0, 1'b1, 0);
        // lockstep fault on core 1 in RUN cycle 2
        dcyc = '{8, 8, NEVER, NEVER};
        do_run(4'b0011, 0, 1, 2, 1'b0, 1'b1, 0);
        // timeout, then done coinciding with the timeout cycle
        dcyc = '{NEVER, NEVER, NEVER, NEVER};
        do_run(4'b0001, 5, -1, 0, 1'b0, 1'b0, 0);
        dcyc = '{6, NEVER, NEVER, NEVER};
        do_run(4'b0001, 5, -1, 0, 1'b0, 1'b0, 0);
        // reset in RUN cycle 4 with a partially filled doneMask
        dcyc = '{NEVER, 2, 50, NEVER};
        do_run(4'b0110, 0, -1, 0, 1'b1, 1'b0, 4);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            m = NC'($urandom_range(1, 15));
            lim = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int i = 0; i < NC; i++)
                dcyc[i] = (lim != 0 && $urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 14));
            fc = -1;
            fcy = 0;
            if ($urandom_range(0, 2) == 0) begin
                for (int i = NC - 1; i >= 0; i--) begin
                    if (m[i] && (m & ((NC'(1) << i) - NC'(1))) != '0) fc = i;
                end
                fcy = int'($urandom_range(1, 10));
            end
            do_run(m, lim, fc, fcy, 1'($urandom), 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
